spi_mstr_param: RTL and testbench
=================================

# spi_mstr_param

Parametrised SPI master: the next-generation replacement for the fixed 16-bit, single-slave SPI master used by the inertial sensor and A2D interfaces. It shifts out a WIDTH-bit command and captures a WIDTH-bit response. New in this generation:
- SCLK rate set by parameter.
- Up to NUM_SS slave selects, chosen per transfer.
- Per-transfer MSB-first or LSB-first order.
- A busy output; commands written while busy are ignored.

## Interface
Parameters:
- WIDTH, 16: bits per transfer, 8..32.
- DIV_BITS, 5: SCLK period P = 2^DIV_BITS clk cycles, 3..8.
- NUM_SS, 1: number of active-low slave selects, 1..8.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wrt  input  1  start pulse; accepted only when busy=0.
- cmd  input  WIDTH  command to send; loaded when wrt is accepted.
- ss_sel  input  3  slave index; latched when wrt is accepted.
- lsb_first  input  1  bit order; latched when wrt is accepted (1 = LSB first).
- MISO  input  1  serial data from slave.
- SS_n  output  NUM_SS  slave selects; at most one bit low at a time.
- SCLK  output  1  serial clock; idles high.
- MOSI  output  1  serial data to slave.
- busy  output  1  high from the edge after wrt acceptance until the transfer completes.
- done  output  1  set at transfer end; cleared on the next accepted wrt.
- rd_data  output  WIDTH  received word, assembled in the latched bit order.

## Operation
- Reset values: SS_n all 1, SCLK 1, MOSI 0, busy 0, done 0, rd_data 0. The SCLK counter resets to PRE.
  - PRE = 2^(DIV_BITS-1) + 2^(DIV_BITS-2) - 1, which is 23 for DIV_BITS=5.
  - The bit counter resets to 0.
- State machine: IDLE -> FRONT -> GO -> BACK -> IDLE.
  - IDLE: on wrt, load the shift register with cmd, latch ss_sel and lsb_first, clear done, go to FRONT.
  - FRONT: no shifting. On the first SCLK fall, go to GO.
  - GO: sample MISO on each clk edge where SCLK rises. Shift on each SCLK fall. After WIDTH-1 shifts, go to BACK.
  - BACK: wait for the final fall point, then perform shift WIDTH. On that same edge: SCLK does not fall, SS_n deasserts, busy drops, done sets, go to IDLE.
- SCLK is the MSB of a DIV_BITS-bit counter.
  - The counter increments every clk while selected.
  - It is forced to PRE whenever no slave is selected.
- MOSI is the shift-register MSB, or the LSB when lsb_first=1.
- Each shift inserts the sampled MISO bit at the opposite end of the shift register from MOSI.
- rd_data shifts on every shift edge: left when lsb_first=0 (new bit at rd_data[0]), right when lsb_first=1 (new bit at rd_data[WIDTH-1]). After done it holds the full word.
- ss_sel >= NUM_SS: the transfer proceeds with SS_n[0] selected.
- wrt while busy=1: ignored; cmd, ss_sel and lsb_first are not sampled.
- wrt in the same cycle as done sets: not accepted, because busy is still 1 in that cycle.
- Asynchronous reset mid-transfer: every output returns to its reset value immediately and the FSM returns to IDLE.

## Timing
- Cycle 0: wrt sampled. Cycle 1: SS_n[sel] low, busy high, done low.
- Let F = 2^(DIV_BITS-2) + 1 (9 for DIV_BITS=5), counted in cycles after SS_n falls.
- First SCLK fall (front porch): cycle F. Then rising edge k at cycle F + P/2 + kP, and shift k at cycle F + kP, for k = 0..WIDTH-1 and k = 1..WIDTH respectively.
- Transfer end: SS_n high, done high and busy low at cycle F + WIDTH·P after SS_n fell. For the defaults this is cycle 521, i.e. 522 clk after wrt.
- Minimum idle between transfers: 1 cycle (the wrt cycle).

## Test plan
- WIDTH=16, DIV_BITS=5, cmd=16'hA5C3, lsb_first=0, slave model returns 16'h3C5A -> MOSI bits 1010_0101_1100_0011 on successive SCLK falls; rd_data=16'h3C5A; done rises 522 clk after wrt; exactly 16 SCLK rises.
- Same transfer with lsb_first=1 -> MOSI order 1100_0011_1010_0101 (LSB of cmd first); rd_data=16'h3C5A with slave sending LSB first.
- NUM_SS=4, ss_sel=2, then ss_sel=5 -> only SS_n=4'b1011 low for the first transfer; only SS_n=4'b1110 low for the second.
- WIDTH=8, DIV_BITS=3, cmd=8'h81 -> P=8, first fall 3 clk after SS_n falls, done 67 clk after SS_n falls, rd_data matches slave byte.
- wrt with cmd=16'hFFFF pulsed at cycle 100 of a 16'h0000 transfer -> ignored; MOSI stays 0 throughout; busy stays high until normal completion.
- rst_n asserted at cycle 200 of a transfer -> same-cycle SS_n all 1, SCLK 1, busy 0, done 0, rd_data 0; a later wrt runs a full, correct transfer.

Source files
------------

// File: rtl/spi_mstr_param.sv
// spi_mstr_param: parametrised SPI master (SCLK idles high, MOSI changes on
// SCLK fall, MISO sampled on SCLK rise). Shifts out a WIDTH-bit command and
// captures a WIDTH-bit response on one of NUM_SS active-low slave selects.
//
// Ports:
//   clk, rst_n   system clock (posedge), asynchronous active-low reset
//   wrt          start pulse, accepted only while busy=0
//   cmd          command word, loaded on accepted wrt
//   ss_sel       slave index, latched on accepted wrt (out of range -> slave 0)
//   lsb_first    bit order, latched on accepted wrt (1 = LSB first)
//   MISO         serial data from slave
//   SS_n         active-low slave selects, at most one low
//   SCLK         serial clock, MSB of the DIV_BITS-bit divider
//   MOSI         serial data to slave
//   busy         transfer in progress
//   done         set at transfer end, cleared on next accepted wrt
//   rd_data      received word, assembled in the latched bit order
module spi_mstr_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIV_BITS = 5,
  parameter int unsigned NUM_SS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [WIDTH-1:0]  cmd,
  input  logic [2:0]        ss_sel,
  input  logic              lsb_first,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  // Divider preload: SCLK high, first fall lands 2^(DIV_BITS-2)+1 cycles after select.
  localparam logic [DIV_BITS-1:0] PRE =
    DIV_BITS'((1 << (DIV_BITS - 1)) + (1 << (DIV_BITS - 2)) - 1);
  localparam logic [DIV_BITS-1:0] RISE_PT = DIV_BITS'((1 << (DIV_BITS - 1)) - 1);
  localparam logic [DIV_BITS-1:0] FALL_PT = '1;
  localparam logic [CNT_W-1:0]    LAST_GO = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, FRONT, GO, BACK} state_t;

  state_t               state, state_nxt;
  logic [DIV_BITS-1:0]  sclk_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WIDTH-1:0]     shft;
  logic                 miso_q;
  logic                 lsb_q;

  logic                 load_c, smp_c, shift_c, end_c;
  logic                 rise_c, fall_c;
  logic [2:0]           sel_eff_c;
  logic [NUM_SS-1:0]    ss_init_c;
  logic [WIDTH-1:0]     cmd_rev_c;

  // Edge points of the divider: next clk edge makes SCLK rise / fall.
  assign rise_c = (sclk_cnt == RISE_PT);
  assign fall_c = (sclk_cnt == FALL_PT);

  // LSB-first commands are loaded bit-reversed so MOSI is always the register MSB.
  assign MOSI = shft[WIDTH-1];
  assign SCLK = sclk_cnt[DIV_BITS-1];

  // Slave select decode with out-of-range fallback to slave 0.
  always_comb begin
    sel_eff_c = (32'(ss_sel) < NUM_SS) ? ss_sel : 3'd0;
    ss_init_c = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      ss_init_c[i] = (32'(sel_eff_c) != i);
    end
  end

  // Bit reversal of cmd for LSB-first loading.
  always_comb begin
    cmd_rev_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cmd_rev_c[i] = cmd[WIDTH-1-i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    smp_c     = 1'b0;
    shift_c   = 1'b0;
    end_c     = 1'b0;
    case (state)
      IDLE: begin
        if (wrt) begin
          load_c    = 1'b1;
          state_nxt = FRONT;
        end
      end
      FRONT: begin
        if (fall_c) state_nxt = GO;
      end
      GO: begin
        smp_c = rise_c;
        if (fall_c) begin
          shift_c = 1'b1;
          if (bit_cnt == LAST_GO) state_nxt = BACK;
        end
      end
      BACK: begin
        smp_c = rise_c;
        if (fall_c) begin
          shift_c   = 1'b1;
          end_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Divider, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_cnt <= PRE;
      bit_cnt  <= '0;
      shft     <= '0;
      miso_q   <= 1'b0;
      lsb_q    <= 1'b0;
      SS_n     <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
    end else begin
      // Divider held at PRE whenever no slave is selected.
      if (state == IDLE || end_c) sclk_cnt <= PRE;
      else                        sclk_cnt <= sclk_cnt + 1'b1;

      if (load_c) begin
        shft    <= lsb_first ? cmd_rev_c : cmd;
        lsb_q   <= lsb_first;
        SS_n    <= ss_init_c;
        busy    <= 1'b1;
        done    <= 1'b0;
        bit_cnt <= '0;
      end

      if (smp_c) miso_q <= MISO;

      if (shift_c) begin
        shft    <= {shft[WIDTH-2:0], miso_q};
        rd_data <= lsb_q ? {miso_q, rd_data[WIDTH-1:1]} : {rd_data[WIDTH-2:0], miso_q};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (end_c) begin
        SS_n <= '1;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_mstr_param.sv
// Bench for spi_mstr_param: two instances (16-bit/DIV 5/4 slaves and
// 8-bit/DIV 3/1 slave) driven by a slave model; expectations come from the
// transfer-level timing and bit-order rules.
module tb_spi_mstr_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic        use_b;
  logic [31:0] cmd_v;
  logic [2:0]  ss_sel;
  logic        lsb_first;
  logic        MISO;

  logic        wrt_a, wrt_b;
  logic [3:0]  ss_a;
  logic        ss_b;
  logic        sclk_a, sclk_b, mosi_a, mosi_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] rd_a;
  logic [7:0]  rd_b;

  logic        obs_sclk, obs_mosi, obs_busy, obs_done;
  logic [31:0] obs_ss, obs_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign wrt_a = wrt & ~use_b;
  assign wrt_b = wrt & use_b;

  assign obs_sclk = use_b ? sclk_b : sclk_a;
  assign obs_mosi = use_b ? mosi_b : mosi_a;
  assign obs_busy = use_b ? busy_b : busy_a;
  assign obs_done = use_b ? done_b : done_a;
  assign obs_ss   = use_b ? {31'h7FFF_FFFF, ss_b} : {28'hFFF_FFFF, ss_a};
  assign obs_rd   = use_b ? {24'd0, rd_b} : {16'd0, rd_a};

  spi_mstr_param #(.WIDTH(16), .DIV_BITS(5), .NUM_SS(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_a), .cmd(cmd_v[15:0]), .ss_sel(ss_sel),
    .lsb_first(lsb_first), .MISO(MISO), .SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a),
    .busy(busy_a), .done(done_a), .rd_data(rd_a)
  );

  spi_mstr_param #(.WIDTH(8), .DIV_BITS(3), .NUM_SS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wrt(wrt_b), .cmd(cmd_v[7:0]), .ss_sel(ss_sel),
    .lsb_first(lsb_first), .MISO(MISO), .SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .busy(busy_b), .done(done_b), .rd_data(rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit k on the wire for word v of width w in the given order.
  function automatic logic wire_bit(input logic [31:0] v, input bit lsb, input int w, input int k);
    logic [31:0] t;
    t = v;
    return lsb ? t[k] : t[w-1-k];
  endfunction

  // One transfer from the current negedge. ign_at: cycle (after SS_n falls) to
  // pulse a spurious wrt with all-ones cmd, -1 for none. rst_at: cycle to
  // assert reset mid-transfer, -1 for none.
  task automatic run_xfer(input bit b, input logic [31:0] cmd, input logic [2:0] sel,
                          input bit lsb, input logic [31:0] sw,
                          input int ign_at, input int rst_at);
    int w, db, p, f, nss, sel_eff, rel, rises, first_fall, k;
    logic [31:0] mask, exp_ss, mosi_got;
    bit prev_sclk, ss_bad;
    w   = b ? 8 : 16;
    db  = b ? 3 : 5;
    nss = b ? 1 : 4;
    p   = 1 << db;
    f   = (1 << (db - 2)) + 1;
    mask    = (32'd1 << w) - 32'd1;
    sel_eff = (int'(sel) < nss) ? int'(sel) : 0;
    exp_ss  = ~(32'd1 << sel_eff);

    use_b     = b;
    cmd_v     = cmd;
    ss_sel    = sel;
    lsb_first = lsb;
    MISO      = wire_bit(sw, lsb, w, 0);
    wrt       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wrt = 1'b0;
    // Inputs after acceptance must not matter.
    cmd_v     = $urandom;
    ss_sel    = 3'($urandom_range(0, 7));
    lsb_first = 1'($urandom_range(0, 1));
    chk("ss_start", obs_ss, exp_ss);
    chk("busy_start", 32'(obs_busy), 32'd1);
    chk("done_start", 32'(obs_done), 32'd0);

    rel = 0; rises = 0; first_fall = -1; mosi_got = '0;
    ss_bad = 1'b0; prev_sclk = obs_sclk;
    while (rel < f + w * p + 40) begin
      if (rel == rst_at) begin
        rst_n = 1'b0;
        wrt   = 1'b0;
        #1;
        chk("rst_ss", obs_ss, 32'hFFFF_FFFF);
        chk("rst_sclk", 32'(obs_sclk), 32'd1);
        chk("rst_mosi", 32'(obs_mosi), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_done", 32'(obs_done), 32'd0);
        chk("rst_rd", obs_rd, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (obs_done) break;
      if (obs_ss !== exp_ss) ss_bad = 1'b1;
      if (obs_sclk && !prev_sclk) begin
        k = rises;
        rises++;
        if (k < w) mosi_got[lsb ? k : w - 1 - k] = obs_mosi;
        MISO = (k + 1 < w) ? wire_bit(sw, lsb, w, k + 1) : 1'b0;
      end
      if (!obs_sclk && prev_sclk && first_fall < 0) first_fall = rel;
      if (rel == ign_at) begin
        wrt = 1'b1; cmd_v = '1; ss_sel = 3'd1; lsb_first = ~lsb;
      end else if (rel == ign_at + 1) begin
        wrt = 1'b0;
      end
      prev_sclk = obs_sclk;
      @(negedge clk);
      rel++;
    end
    wrt = 1'b0;
    chk("end_cycle", 32'(rel), 32'(f + w * p));
    chk("first_fall", 32'(first_fall), 32'(f));
    chk("sclk_rises", 32'(rises), 32'(w));
    chk("mosi_word", mosi_got & mask, cmd & mask);
    chk("rd_data", obs_rd, sw & mask);
    chk("ss_held", 32'(ss_bad), 32'd0);
    chk("ss_end", obs_ss, 32'hFFFF_FFFF);
    chk("busy_end", 32'(obs_busy), 32'd0);
    chk("done_end", 32'(obs_done), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wrt = 1'b0; use_b = 1'b0; cmd_v = '0;
    ss_sel = '0; lsb_first = 1'b0; MISO = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_ss_a", 32'(ss_a), 32'hF);
    chk("por_ss_b", 32'(ss_b), 32'h1);
    chk("por_sclk", {30'd0, sclk_a, sclk_b}, 32'd3);
    chk("por_mosi", {30'd0, mosi_a, mosi_b}, 32'd0);
    chk("por_busy", {30'd0, busy_a, busy_b}, 32'd0);
    chk("por_done", {30'd0, done_a, done_b}, 32'd0);
    chk("por_rd", {8'd0, rd_a, rd_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(1'b0, 32'hA5C3, 3'd0, 1'b0, 32'h3C5A, -1, -1);
    run_xfer(1'b0, 32'hA5C3, 3'd0, 1'b1, 32'h3C5A, -1, -1);
    run_xfer(1'b0, $urandom, 3'd2, 1'b0, $urandom, -1, -1);
    run_xfer(1'b0, $urandom, 3'd5, 1'b1, $urandom, -1, -1);
    run_xfer(1'b1, 32'h81, 3'd0, 1'b0, $urandom, -1, -1);
    run_xfer(1'b1, $urandom, 3'd3, 1'b1, $urandom, -1, -1);
    run_xfer(1'b0, 32'h0000, 3'd1, 1'b0, $urandom, 100, -1);
    // Spurious wrt sampled on the edge where done sets.
    run_xfer(1'b0, $urandom, 3'd3, 1'b0, $urandom, 9 + 16 * 32 - 1, -1);
    run_xfer(1'b1, $urandom, 3'd0, 1'b0, $urandom, 3 + 8 * 8 - 1, -1);
    run_xfer(1'b0, $urandom, 3'd0, 1'b0, $urandom, -1, 200);
    run_xfer(1'b0, 32'hBEEF, 3'd1, 1'b1, 32'h1234, -1, -1);

    for (int i = 0; i < 10; i++) begin
      run_xfer(1'(i % 2), $urandom, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), $urandom, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
